// File: rtl/beta_memio.sv
// Memory and I/O subsystem for the Beta processor: word RAM, an output byte FIFO,
// a synchronized input port and a reloadable interval timer that raises irq.
module beta_memio #(
    parameter int          RAM_WORDS = 4096,
    parameter logic [30:0] IRQ_VEC   = 31'h0000_0008
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ma,
    input  logic [31:0] mdout,
    input  logic        mwe,
    output logic [31:0] mdin,
    output logic        irq,
    output logic [30:0] xadr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic [7:0]  in_data
);

    localparam int ADDR_W = $clog2(RAM_WORDS);

    localparam logic [28:0] OUT_WA     = 29'h1000_0000;
    localparam logic [28:0] IN_WA      = 29'h1000_0001;
    localparam logic [28:0] TRELOAD_WA = 29'h1000_0002;
    localparam logic [28:0] TSTAT_WA   = 29'h1000_0003;

    // Supervisor bit and byte offset take no part in decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ma[31], ma[1:0]};

    logic [28:0]       wa;
    logic [ADDR_W-1:0] ram_idx;
    logic              is_ram;
    logic              is_out;
    logic              is_in;
    logic              is_treload;
    logic              is_tstat;

    assign wa         = ma[30:2];
    assign ram_idx    = ma[ADDR_W+1:2];
    assign is_ram     = (ma[30:ADDR_W+2] == '0);
    assign is_out     = (wa == OUT_WA);
    assign is_in      = (wa == IN_WA);
    assign is_treload = (wa == TRELOAD_WA);
    assign is_tstat   = (wa == TSTAT_WA);

    // RAM is not reset; the combinational read happens before the write edge,
    // which gives read-first behaviour for a same-cycle write.
    logic [31:0] ram_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (mwe && is_ram) begin
            ram_q[ram_idx] <= mdout;
        end
    end

    // Output handshake: a byte transfers on a rising edge where out_valid and
    // out_ready are both 1; out_data holds steady while out_valid=1 and out_ready=0.
    logic [7:0] fifo_q [4];
    logic [7:0] fifo_d [4];
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] count_q, count_d;
    logic       push;
    logic       pop;

    assign out_valid = (count_q != 3'd0);
    assign out_data  = out_valid ? fifo_q[rd_ptr_q] : 8'h00;
    assign pop       = out_valid && out_ready;
    assign push      = mwe && is_out && (count_q != 3'd4);

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = mdout[7:0];
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    logic [7:0] sync1_q, sync1_d;
    logic [7:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = in_data;
        sync2_d = sync1_q;
    end

    logic [31:0] reload_q, reload_d;
    logic [31:0] cnt_q, cnt_d;
    logic        pending_q, pending_d;
    logic        irq_q, irq_d;
    logic        tick;

    always_comb begin
        tick     = 1'b0;
        reload_d = reload_q;
        cnt_d    = cnt_q;
        if (reload_q != 32'd0) begin
            if (cnt_q == 32'd0) begin
                tick  = 1'b1;
                cnt_d = reload_q;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
        end
        if (mwe && is_treload) begin
            reload_d = mdout;
            cnt_d    = mdout;
        end
        // A timer tick in the same cycle as a status write keeps pending set.
        if (tick) begin
            pending_d = 1'b1;
        end else if (mwe && is_tstat) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        irq_d = pending_q;
    end

    logic [31:0] mdin_q, mdin_d;

    always_comb begin
        mdin_d = 32'd0;
        if (is_ram) begin
            mdin_d = ram_q[ram_idx];
        end else if (is_out) begin
            mdin_d = {29'd0, count_q};
        end else if (is_in) begin
            mdin_d = {24'd0, sync2_q};
        end else if (is_treload) begin
            mdin_d = reload_q;
        end else if (is_tstat) begin
            mdin_d = {31'd0, pending_q};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 8'h00;
            end
            rd_ptr_q  <= 2'd0;
            wr_ptr_q  <= 2'd0;
            count_q   <= 3'd0;
            sync1_q   <= 8'h00;
            sync2_q   <= 8'h00;
            reload_q  <= 32'd0;
            cnt_q     <= 32'd0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
            mdin_q    <= 32'd0;
        end else begin
            fifo_q    <= fifo_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            reload_q  <= reload_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
            mdin_q    <= mdin_d;
        end
    end

    assign mdin = mdin_q;
    assign irq  = irq_q;
    assign xadr = IRQ_VEC;

endmodule

// File: tb/tb_beta_memio.sv
// Directed self-checking bench for beta_memio: RAM, output FIFO, input port,
// timer interrupt and asynchronous reset behaviour.
module tb_beta_memio;

    localparam logic [31:0] A_OUT     = 32'h4000_0000;
    localparam logic [31:0] A_IN      = 32'h4000_0004;
    localparam logic [31:0] A_TRELOAD = 32'h4000_0008;
    localparam logic [31:0] A_TSTAT   = 32'h4000_000C;
    localparam logic [31:0] A_IDLE    = 32'h7000_0000;

    logic        clk;
    logic        reset_n;
    logic [31:0] ma;
    logic [31:0] mdout;
    logic        mwe;
    logic [31:0] mdin;
    logic        irq;
    logic [30:0] xadr;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  in_data;

    int n_cmp;
    int n_err;
    logic [31:0] rdata;

    beta_memio dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ma        (ma),
        .mdout     (mdout),
        .mwe       (mwe),
        .mdin      (mdin),
        .irq       (irq),
        .xadr      (xadr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        ma    = addr;
        mdout = data;
        mwe   = 1'b1;
        cycle();
        mwe   = 1'b0;
        ma    = A_IDLE;
        mdout = 32'd0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        ma  = addr;
        mwe = 1'b0;
        cycle();
        data = mdin;
        ma   = A_IDLE;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset_n   = 1'b0;
        ma        = A_IDLE;
        mdout     = 32'd0;
        mwe       = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;

        // Reset state, sampled before any clock edge
        #2;
        check("rst_mdin", mdin, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("xadr", {1'b0, xadr}, 32'h0000_0008);
        cycle();
        cycle();
        #2 reset_n = 1'b1;
        cycle();

        // RAM write/read, unmapped read, read-first, ignored address bits
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, rdata);
        check("ram_rd", rdata, 32'hDEAD_BEEF);
        rd(32'h4000_0100, rdata);
        check("unmapped_rd", rdata, 32'd0);
        ma = 32'h10; mdout = 32'h1234_5678; mwe = 1'b1;
        cycle();
        check("ram_read_first", mdin, 32'hDEAD_BEEF);
        mwe = 1'b0;
        rd(32'h13, rdata);
        check("ram_byte_ofs", rdata, 32'h1234_5678);
        rd(32'h8000_0010, rdata);
        check("ram_super_bit", rdata, 32'h1234_5678);
        wr(32'h4000_0100, 32'hFFFF_FFFF);
        rd(32'h4000_0100, rdata);
        check("unmapped_wr", rdata, 32'd0);
        rd(32'h0, rdata);
        check("ram_other_word", rdata === 32'hFFFF_FFFF ? 32'd1 : 32'd0, 32'd0);

        // Input synchronizer: two edges before the new value is visible
        in_data = 8'h5A;
        ma = A_IN;
        cycle();
        check("in_edge1", mdin, 32'd0);
        cycle();
        check("in_edge2", mdin, 32'd0);
        cycle();
        check("in_edge3", mdin, 32'h0000_005A);
        wr(A_IN, 32'hFFFF_FFFF);
        rd(A_IN, rdata);
        check("in_wr_ignored", rdata, 32'h0000_005A);

        // FIFO overflow: fifth byte dropped
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(A_OUT, 32'h41 + i);
        end
        rd(A_OUT, rdata);
        check("fifo_count_full", rdata, 32'd4);
        cycle();
        check("fifo_hold_data", {24'd0, out_data}, 32'h41);
        check("fifo_hold_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("fifo_drain_data", {24'd0, out_data}, 32'h41 + i);
            cycle();
        end
        check("fifo_empty_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        rd(A_OUT, rdata);
        check("fifo_count_empty", rdata, 32'd0);

        // Simultaneous push and pop at count 2
        wr(A_OUT, 32'h61);
        wr(A_OUT, 32'h62);
        out_ready = 1'b1;
        ma = A_OUT; mdout = 32'h63; mwe = 1'b1;
        cycle();
        mwe = 1'b0; ma = A_IDLE; out_ready = 1'b0;
        rd(A_OUT, rdata);
        check("fifo_pushpop_count", rdata, 32'd2);
        check("fifo_pushpop_head", {24'd0, out_data}, 32'h62);
        out_ready = 1'b1;
        cycle();
        check("fifo_pushpop_next", {24'd0, out_data}, 32'h63);
        cycle();
        check("fifo_pushpop_empty", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Push to a full FIFO is dropped even with a pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            wr(A_OUT, 32'h71 + i);
        end
        out_ready = 1'b1;
        ma = A_OUT; mdout = 32'h75; mwe = 1'b1;
        cycle();
        mwe = 1'b0; ma = A_IDLE; out_ready = 1'b0;
        rd(A_OUT, rdata);
        check("fifo_full_pushpop_count", rdata, 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("fifo_full_drain", {24'd0, out_data}, 32'h72 + i);
            cycle();
        end
        check("fifo_full_drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Timer: reload 3 -> period 4, irq one edge behind pending
        wr(A_TRELOAD, 32'd3);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            check("tmr_irq_low", {31'd0, irq}, 32'd0);
        end
        rd(A_TSTAT, rdata);
        check("tmr_tstat_set", rdata, 32'd1);
        check("tmr_irq_rise", {31'd0, irq}, 32'd1);
        wr(A_TSTAT, 32'd0);
        check("tmr_irq_lag", {31'd0, irq}, 32'd1);
        cycle();
        check("tmr_irq_cleared", {31'd0, irq}, 32'd0);
        cycle();
        check("tmr_irq_wait", {31'd0, irq}, 32'd0);
        cycle();
        check("tmr_irq_period", {31'd0, irq}, 32'd1);
        wr(A_TSTAT, 32'hFFFF_FFFF);
        cycle();
        check("tmr_irq_clr2", {31'd0, irq}, 32'd0);
        wr(A_TSTAT, 32'd5);
        cycle();
        check("tmr_set_beats_clr", {31'd0, irq}, 32'd1);
        rd(A_TSTAT, rdata);
        check("tmr_tstat_kept", rdata, 32'd1);
        rd(A_TRELOAD, rdata);
        check("tmr_reload_rd", rdata, 32'd3);

        // Mid-operation reset with 3 queued bytes and irq high
        for (int i = 0; i < 3; i++) begin
            wr(A_OUT, 32'h81 + i);
        end
        rd(32'h10, rdata);
        check("pre_rst_ram", rdata, 32'h1234_5678);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_irq", {31'd0, irq}, 32'd0);
        check("async_rst_mdin", mdin, 32'd0);
        check("async_rst_data", {24'd0, out_data}, 32'd0);
        cycle();
        #2 reset_n = 1'b1;
        #1;
        rd(A_IN, rdata);
        check("post_rst_sync", rdata, 32'd0);
        rd(A_OUT, rdata);
        check("post_rst_count", rdata, 32'd0);
        rd(A_TRELOAD, rdata);
        check("post_rst_reload", rdata, 32'd0);
        rd(32'h10, rdata);
        check("post_rst_ram", rdata, 32'h1234_5678);
        for (int i = 0; i < 6; i++) begin
            cycle();
        end
        rd(A_TSTAT, rdata);
        check("reload0_no_pending", rdata, 32'd0);
        check("reload0_no_irq", {31'd0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/beta_memio.md
BETA_MEMIO -- requirements
Module: beta_memio

Interface
REQ-001 SHALL take parameter RAM_WORDS, default 4096: number of 32-bit RAM words; power of two, at most 8192.
REQ-002 SHALL take parameter IRQ_VEC, default 31'h0000_0008: interrupt handler address driven on xadr.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ma  in  32  processor memory address, byte address; bit 31 (supervisor) ignored for decode.
REQ-006 mdout  in  32  processor write data.
REQ-007 mwe  in  1  processor write enable, qualifies ma/mdout in the same cycle.
REQ-008 mdin  out  32  registered read data to the processor.
REQ-009 irq  out  1  level interrupt request to the processor.
REQ-010 xadr  out  31  interrupt vector; constant IRQ_VEC.
REQ-011 out_data  out  8  head byte of the output FIFO.
REQ-012 out_valid  out  1  output FIFO non-empty.
REQ-013 out_ready  in  1  consumer accepts out_data when out_valid is also high.
REQ-014 in_data  in  8  asynchronous external input byte (switches).

Function
REQ-015 SHALL decode ma[30:0] as follows: RAM at 0 .. RAM_WORDS*4-1, indexed by ma[2+log2(RAM_WORDS)-1:2]; OUT at 0x4000_0000; IN at 0x4000_0004; TRELOAD at 0x4000_0008; TSTAT at 0x4000_000C. Any other address reads 0 and ignores writes; ma[1:0] ignored.
REQ-016 Read latency SHALL be exactly one cycle: mdin after edge N holds the read data for the ma presented before edge N, every cycle, whatever the value of mwe.
REQ-017 RAM write SHALL occur at the edge where mwe=1; a same-cycle read of that address SHALL return the old data (read-first).
REQ-018 OUT write SHALL push mdout[7:0] into a 4-entry FIFO when it is not full; a push when full SHALL be dropped, even if a pop occurs in the same cycle.
REQ-019 OUT read SHALL return {29'b0, count[2:0]}, where count (0..4) is the value before that cycle's push or pop.
REQ-020 A pop SHALL occur when out_valid and out_ready are both 1. A simultaneous push and pop on a non-full FIFO SHALL leave count unchanged.
REQ-021 out_data SHALL be the oldest entry and SHALL be stable while out_valid=1 and out_ready=0. FIFO pointers wrap modulo 4.
REQ-022 in_data SHALL pass through a 2-flop synchronizer. An IN read SHALL return {24'b0, synchronized value}. IN writes SHALL be ignored.
REQ-023 TRELOAD SHALL be a 32-bit R/W register. Writing it SHALL also load the count register cnt with mdout.
REQ-024 When reload is not 0, each cycle: if cnt is 0, set pending and reload cnt from reload; otherwise decrement cnt. The resulting period SHALL be reload+1 cycles.
REQ-025 When reload is 0, cnt SHALL hold and pending SHALL not be set.
REQ-026 A TSTAT read SHALL return {31'b0, pending}. A TSTAT write of any value SHALL clear pending. A set in the same cycle SHALL take priority over the clear.
REQ-027 irq SHALL equal pending, registered, with no combinational path from ma or mwe.

Reset
REQ-028 While reset_n=0: mdin=0, irq=0, out_valid=0, out_data=0, FIFO count=0, reload=0, cnt=0, pending=0, synchronizer flops=0. Effect SHALL be immediate, without a clock edge.
REQ-029 RAM contents SHALL NOT be reset.
REQ-030 A reset asserted mid-operation SHALL discard queued FIFO bytes and any pending interrupt.
REQ-031 After reset_n rises, the first edge SHALL act on the inputs normally.

Verification
REQ-032 RAM: write 0xDEADBEEF to 0x10 with mwe=1, then read 0x10 with mwe=0 -> mdin=0xDEADBEEF one cycle later; read of 0x4000_0100 -> mdin=0.
REQ-033 FIFO: hold out_ready=0, write 0x41,0x42,0x43,0x44,0x45 to OUT -> OUT read returns 4; raise out_ready -> out_data sequence 0x41..0x44, 0x45 never appears, out_valid falls after 4 pops.
REQ-034 FIFO simultaneous: with 2 entries and out_ready=1, push one byte -> count stays 2, order preserved.
REQ-035 Timer: write TRELOAD=3 -> irq rises 5 cycles after the write edge, then every 4 cycles; TSTAT write clears irq; a clear coincident with a set leaves irq=1.
REQ-036 IN: change in_data to 0x5A -> IN read returns 0x5A no earlier than 2 edges after the change.
REQ-037 Reset: with FIFO holding 3 bytes and irq=1, pulse reset_n low between edges -> out_valid, irq and mdin go to 0 immediately; RAM data is retained.
